mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Parametrised, variable-latency data-memory access unit for the MIPS pipeline's M stage. It replaces the single-cycle, fixed 32-bit byte-enable/extension path with a registered request/acknowledge bus master. It supports 32- or 64-bit data width, byte/half/word/(dword) loads and stores with sign or zero extension, and alignment exceptions. A wait-state timeout holds the pipeline through a stall and releases it if the bus never acknowledges.

## Interface
- DATA_W, 32: data bus width; legal values 32 or 64; LANES = DATA_W/8.
- ADDR_W, 32: address width.
- MAX_WAIT, 15: bus cycles without acknowledge before timeout; range 1..255.

- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  M-stage instruction performs a memory access.
- in_write  in  1  1 = store, 0 = load.
- in_size  in  2  0 byte, 1 half, 2 word, 3 dword (legal only when DATA_W=64).
- in_signed  in  1  load sign-extends when 1.
- in_addr  in  ADDR_W  effective address (ALU result).
- in_wdata  in  DATA_W  store data, right-aligned.
- bus_req  out  1  request, held until acknowledge or timeout.
- bus_we  out  1  write request.
- bus_addr  out  ADDR_W  word/dword-aligned address (low log2(LANES) bits 0).
- bus_wdata  out  DATA_W  store data shifted to lane.
- bus_byteen  out  LANES  active lanes; all 0 for loads.
- bus_ack  in  1  one-cycle acknowledge; bus_rdata valid in the same cycle.
- bus_rdata  in  DATA_W  read data.
- stall  out  1  combinational; freezes upstream stages and holds all in_* stable.
- out_valid  out  1  one-cycle pulse: access completed normally.
- out_rdata  out  DATA_W  extended load result (0 for stores).
- exc_adel / exc_ades  out  1  misaligned/illegal load / store, one-cycle pulse.
- exc_timeout  out  1  bus timeout, one-cycle pulse.

## Operation
- States: IDLE, WAIT, DONE.
- Alignment: off = in_addr[log2(LANES)-1:0]; byte always aligned; half needs off[0]=0; word needs off[1:0]=0; dword needs off=0. size 3 with DATA_W=32 is illegal.
- IDLE, in_valid=1 and aligned: latch request; go to WAIT; bus_req=1 from the next cycle.
- IDLE, in_valid=1 and misaligned or illegal: no bus request; go to DONE and pulse exc_adel (load) or exc_ades (store) there.
- IDLE, in_valid=0: stay.
- WAIT: bus_req=1; wait counter increments every cycle.
  - bus_ack=1: capture and extend data; go to DONE with out_valid.
  - Counter reaches MAX_WAIT with no ack: drop req; go to DONE with exc_timeout.
- DONE: exactly one cycle; stall=0 so the instruction leaves M; in_valid is ignored; go to IDLE.
- stall = (state==WAIT) | (state==IDLE & in_valid).
- Store lanes: bus_wdata = in_wdata << (8*off); bus_byteen = ((1<<(1<<in_size))-1) << off.
- Load extraction: tmp = bus_rdata >> (8*off); keep the low 8<<in_size bits; sign- or zero-extend to DATA_W.
- bus_ack outside WAIT is ignored.

## Timing
- Accept at cycle t: bus_req is high from t+1 to the ack cycle t+1+k (k>=0). DONE and out_valid occur at t+2+k.
- Minimum access is 3 cycles including DONE. Back-to-back accesses have one idle-accept gap: the next accept is in the cycle after DONE.
- Timeout: bus_req is high for MAX_WAIT cycles (t+1..t+MAX_WAIT); exc_timeout at t+1+MAX_WAIT.
- An ack in the final allowed wait cycle wins over timeout.
- Misaligned access: DONE with exc at t+1; bus_req is never asserted.
- bus_addr, bus_we, bus_wdata and bus_byteen are registered and stable for the whole WAIT.
- out_rdata holds its value until the next completion.
- Reset, any state including mid-WAIT: next cycle state=IDLE, counter=0. Every output is 0: bus_req, bus_we, bus_addr, bus_wdata, bus_byteen, out_valid, out_rdata, exc_adel, exc_ades, exc_timeout. stall then follows in_valid combinationally.
- A late ack after reset is ignored.

## Test plan
- DATA_W=32: lb signed, addr 0x1003, bus_rdata 0x80FF_1234 acked after 2 wait cycles -> out_valid at t+4, out_rdata 0xFFFF_FF80, stall high t..t+3.
- DATA_W=32: sh, addr 0x2002, wdata 0x0000_ABCD, ack at t+1 -> bus_addr 0x2000, bus_byteen 4'b1100, bus_wdata 0xABCD_0000, bus_we=1, out_valid at t+2.
- lw at addr 0x0006 -> exc_adel at t+1, no bus_req, out_valid 0; sw at 0x0001 -> exc_ades.
- MAX_WAIT=4, no ack -> bus_req high t+1..t+4, exc_timeout at t+5. Repeat with ack at t+4 -> out_valid, no timeout.
- DATA_W=64: ld at 0x10 with rdata 0x8000_0000_0000_0001 -> out_rdata unchanged. lhu at 0x16 with rdata 0xBEEF_0000_0000_0000 -> 0x0000_0000_0000_BEEF. ld on DATA_W=32 -> exc_adel.
- Reset asserted in the 2nd WAIT cycle, then ack -> all outputs 0 next cycle, ack ignored, no out_valid. A fresh lw after reset completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// M-stage data-memory access unit: registered request/acknowledge bus master with
// lane steering, load extension, alignment exceptions and a wait-state timeout.
module mem_access_unit #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_write,
  input  logic [1:0]            in_size,
  input  logic                  in_signed,
  input  logic [ADDR_W-1:0]     in_addr,
  input  logic [DATA_W-1:0]     in_wdata,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  output logic [DATA_W/8-1:0]   bus_byteen,
  input  logic                  bus_ack,
  input  logic [DATA_W-1:0]     bus_rdata,
  output logic                  stall,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_rdata,
  output logic                  exc_adel,
  output logic                  exc_ades,
  output logic                  exc_timeout,
  output logic [1:0]            fsm_state
);
  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [7:0]        wait_cnt;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [OFF_W-1:0]  off_q;

  logic [OFF_W-1:0]  off;
  logic              aligned;
  logic [LANES-1:0]  lane_mask;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep_mask;
  logic              sign_bit;
  logic [DATA_W-1:0] load_data;

  assign off       = in_addr[OFF_W-1:0];
  assign stall     = (state == WAIT) | ((state == IDLE) & in_valid);
  assign fsm_state = state;

  always_comb begin
    aligned   = 1'b1;
    lane_mask = '1;
    case (in_size)
      2'd0: begin aligned = 1'b1;               lane_mask = LANES'(8'h01); end
      2'd1: begin aligned = ~off[0];            lane_mask = LANES'(8'h03); end
      2'd2: begin aligned = (off[1:0] == 2'b00); lane_mask = LANES'(8'h0F); end
      default: begin aligned = (DATA_W == 64) && (off == '0); lane_mask = '1; end
    endcase
  end

  // Load path works from the request latched at accept so it is valid on the ack cycle.
  always_comb begin
    shifted   = bus_rdata >> {off_q, 3'b000};
    keep_mask = '1;
    sign_bit  = shifted[DATA_W-1];
    case (size_q)
      2'd0: begin keep_mask = DATA_W'(64'hFF);        sign_bit = shifted[7];  end
      2'd1: begin keep_mask = DATA_W'(64'hFFFF);      sign_bit = shifted[15]; end
      2'd2: begin keep_mask = DATA_W'(64'hFFFF_FFFF); sign_bit = shifted[31]; end
      default: begin keep_mask = '1;                  sign_bit = shifted[DATA_W-1]; end
    endcase
    load_data = (shifted & keep_mask) | ((signed_q & sign_bit) ? ~keep_mask : '0);
  end

  // Bus handshake: bus_req rises the cycle after accept and stays high with address,
  // byte enables and data frozen until the single-cycle bus_ack or the timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      off_q       <= '0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_byteen  <= '0;
      out_valid   <= 1'b0;
      out_rdata   <= '0;
      exc_adel    <= 1'b0;
      exc_ades    <= 1'b0;
      exc_timeout <= 1'b0;
    end else begin
      out_valid   <= 1'b0;
      exc_adel    <= 1'b0;
      exc_ades    <= 1'b0;
      exc_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (aligned) begin
              state      <= WAIT;
              wait_cnt   <= '0;
              bus_req    <= 1'b1;
              bus_we     <= in_write;
              bus_addr   <= {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              bus_wdata  <= in_write ? (in_wdata << {off, 3'b000}) : '0;
              bus_byteen <= in_write ? (lane_mask << off) : '0;
              size_q     <= in_size;
              signed_q   <= in_signed;
              off_q      <= off;
            end else begin
              state    <= DONE;
              exc_adel <= ~in_write;
              exc_ades <= in_write;
            end
          end
        end
        WAIT: begin
          if (bus_ack) begin
            state     <= DONE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            out_valid <= 1'b1;
            out_rdata <= bus_we ? '0 : load_data;
          end else if (wait_cnt == 8'(MAX_WAIT - 1)) begin
            state       <= DONE;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            exc_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: 32-bit and 64-bit instances (MAX_WAIT=4) driven
// from a vector table plus hand-written reset-during-wait sequence.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        sel;
  logic        v32, v64, wr, sg, ack;
  logic [1:0]  sz;
  logic [31:0] addr;
  logic [63:0] wdata, rdata;

  logic        req32, we32, stall32, ov32, adel32, ades32, to32;
  logic [31:0] baddr32, bwd32, rd32;
  logic [3:0]  be32;
  logic [1:0]  st32;

  logic        req64, we64, stall64, ov64, adel64, ades64, to64;
  logic [31:0] baddr64;
  logic [63:0] bwd64, rd64;
  logic [7:0]  be64;
  logic [1:0]  st64;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .MAX_WAIT(4)) u32 (
    .clk(clk), .reset(reset), .in_valid(v32), .in_write(wr), .in_size(sz),
    .in_signed(sg), .in_addr(addr), .in_wdata(wdata[31:0]),
    .bus_req(req32), .bus_we(we32), .bus_addr(baddr32), .bus_wdata(bwd32),
    .bus_byteen(be32), .bus_ack(ack), .bus_rdata(rdata[31:0]), .stall(stall32),
    .out_valid(ov32), .out_rdata(rd32), .exc_adel(adel32), .exc_ades(ades32),
    .exc_timeout(to32), .fsm_state(st32));

  mem_access_unit #(.DATA_W(64), .ADDR_W(32), .MAX_WAIT(4)) u64 (
    .clk(clk), .reset(reset), .in_valid(v64), .in_write(wr), .in_size(sz),
    .in_signed(sg), .in_addr(addr), .in_wdata(wdata),
    .bus_req(req64), .bus_we(we64), .bus_addr(baddr64), .bus_wdata(bwd64),
    .bus_byteen(be64), .bus_ack(ack), .bus_rdata(rdata), .stall(stall64),
    .out_valid(ov64), .out_rdata(rd64), .exc_adel(adel64), .exc_ades(ades64),
    .exc_timeout(to64), .fsm_state(st64));

  // Selected-instance view of the outputs.
  logic        o_req, o_we, o_stall;
  logic [31:0] o_baddr;
  logic [63:0] o_bwd, o_rd;
  logic [7:0]  o_be;
  logic [3:0]  o_flags;
  logic [1:0]  o_state;
  always_comb begin
    o_req   = sel ? req64   : req32;
    o_we    = sel ? we64    : we32;
    o_stall = sel ? stall64 : stall32;
    o_baddr = sel ? baddr64 : baddr32;
    o_bwd   = sel ? bwd64   : {32'd0, bwd32};
    o_rd    = sel ? rd64    : {32'd0, rd32};
    o_be    = sel ? be64    : {4'd0, be32};
    o_flags = sel ? {ov64, adel64, ades64, to64} : {ov32, adel32, ades32, to32};
    o_state = sel ? st64    : st32;
  end

  localparam logic [3:0] OK = 4'b1000, ADEL = 4'b0100, ADES = 4'b0010, TMO = 4'b0001;
  localparam int MAXW = 4;

  typedef struct {
    logic        is64;
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          k;          // ack in wait cycle k (0 = first), -1 = never
    logic [3:0]  exp_flags;  // {out_valid, exc_adel, exc_ades, exc_timeout}
    logic [63:0] exp_rdata;
    logic [31:0] exp_baddr;
    logic [7:0]  exp_be;
    logic [63:0] exp_bwd;
  } vec_t;

  vec_t vecs[19];
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int          done_n, req_n, exp_done, exp_req;
    logic [3:0]  flags;
    logic        stall_ok, stable_ok, bwe;
    logic [31:0] baddr;
    logic [7:0]  be;
    logic [63:0] bwd, exp_rd;
    @(posedge clk); #1;
    sel = v.is64; wr = v.wr; sz = v.sz; sg = v.sg; addr = v.addr;
    wdata = v.wdata; rdata = v.rdata; ack = 1'b0;
    if (v.is64) v64 = 1'b1; else v32 = 1'b1;
    if (v.exp_flags == OK) exp_q.push_back(v.exp_rdata);
    #1;
    chk({tag, "_stall_accept"}, 64'(o_stall), 64'd1);
    done_n = 0; req_n = 0; flags = '0; stall_ok = 1'b1; stable_ok = 1'b1;
    bwe = 1'b0; baddr = '0; be = '0; bwd = '0;
    for (int n = 1; n <= 20 && done_n == 0; n++) begin
      @(posedge clk); #1;
      ack = 1'b0;
      if (o_req) req_n++;
      if (n == 1) begin
        bwe = o_we; baddr = o_baddr; be = o_be; bwd = o_bwd;
      end else if (o_req && {o_we, o_baddr, o_be, o_bwd} != {bwe, baddr, be, bwd}) begin
        stable_ok = 1'b0;
      end
      if (o_flags != 4'd0) begin
        done_n = n;
        flags  = o_flags;
      end else begin
        if (!o_stall) stall_ok = 1'b0;
        if (v.k >= 0 && n == v.k + 1) ack = 1'b1;
      end
    end
    chk({tag, "_stall_done"}, 64'(o_stall), 64'd0);
    v32 = 1'b0; v64 = 1'b0; ack = 1'b0;
    if (v.exp_flags == ADEL || v.exp_flags == ADES) begin
      exp_done = 1; exp_req = 0;
    end else if (v.k < 0) begin
      exp_done = MAXW + 1; exp_req = MAXW;
    end else begin
      exp_done = v.k + 2; exp_req = v.k + 1;
    end
    chk({tag, "_done_cycle"}, 64'(done_n), 64'(exp_done));
    chk({tag, "_req_cycles"}, 64'(req_n), 64'(exp_req));
    chk({tag, "_flags"}, 64'(flags), 64'(v.exp_flags));
    chk({tag, "_stall_hold"}, 64'(stall_ok), 64'd1);
    if (exp_req > 0) begin
      chk({tag, "_bus_we"}, 64'(bwe), 64'(v.wr));
      chk({tag, "_bus_addr"}, 64'(baddr), 64'(v.exp_baddr));
      chk({tag, "_bus_byteen"}, 64'(be), 64'(v.exp_be));
      chk({tag, "_bus_wdata"}, bwd, v.exp_bwd);
      chk({tag, "_bus_stable"}, 64'(stable_ok), 64'd1);
    end
    if (exp_q.size() != 0) begin
      exp_rd = exp_q.pop_front();
      chk({tag, "_out_rdata"}, o_rd, exp_rd);
    end
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0; v32 = 1'b0; v64 = 1'b0; wr = 1'b0; sg = 1'b0;
    ack = 1'b0; sz = 2'd0; addr = '0; wdata = '0; rdata = '0;

    //          is64 wr sz sg addr       wdata                     rdata                     k  flags exp_rdata                 baddr     be      bwd
    vecs[0]  = '{0, 0, 0, 1, 32'h1003, 64'h0,                   64'h80FF_1234,            2, OK,   64'hFFFF_FF80,            32'h1000, 8'h00, 64'h0};
    vecs[1]  = '{0, 1, 1, 0, 32'h2002, 64'h0000_ABCD,           64'h0,                    0, OK,   64'h0,                    32'h2000, 8'h0C, 64'hABCD_0000};
    vecs[2]  = '{0, 0, 2, 0, 32'h0006, 64'h0,                   64'h0,                    0, ADEL, 64'h0,                    32'h0,    8'h00, 64'h0};
    vecs[3]  = '{0, 1, 2, 0, 32'h0001, 64'h55,                  64'h0,                    0, ADES, 64'h0,                    32'h0,    8'h00, 64'h0};
    vecs[4]  = '{0, 0, 2, 0, 32'h0040, 64'h0,                   64'hDEAD,                -1, TMO,  64'h0,                    32'h0040, 8'h00, 64'h0};
    vecs[5]  = '{0, 0, 2, 0, 32'h0044, 64'h0,                   64'h1234_5678,            3, OK,   64'h1234_5678,            32'h0044, 8'h00, 64'h0};
    vecs[6]  = '{0, 0, 0, 0, 32'h1003, 64'h0,                   64'h80FF_1234,            1, OK,   64'h80,                   32'h1000, 8'h00, 64'h0};
    vecs[7]  = '{0, 0, 1, 1, 32'h0000, 64'h0,                   64'h0000_8001,            0, OK,   64'hFFFF_8001,            32'h0000, 8'h00, 64'h0};
    vecs[8]  = '{0, 1, 0, 0, 32'h3001, 64'hA5,                  64'h0,                    0, OK,   64'h0,                    32'h3000, 8'h02, 64'hA500};
    vecs[9]  = '{0, 0, 3, 0, 32'h0010, 64'h0,                   64'h0,                    0, ADEL, 64'h0,                    32'h0,    8'h00, 64'h0};
    vecs[10] = '{0, 0, 1, 0, 32'h0003, 64'h0,                   64'h0,                    0, ADEL, 64'h0,                    32'h0,    8'h00, 64'h0};
    vecs[11] = '{1, 0, 3, 0, 32'h0010, 64'h0,                   64'h8000_0000_0000_0001,  1, OK,   64'h8000_0000_0000_0001,  32'h0010, 8'h00, 64'h0};
    vecs[12] = '{1, 0, 1, 0, 32'h0016, 64'h0,                   64'hBEEF_0000_0000_0000,  0, OK,   64'h0000_0000_0000_BEEF,  32'h0010, 8'h00, 64'h0};
    vecs[13] = '{1, 0, 2, 1, 32'h001C, 64'h0,                   64'h8000_0000_0000_0000,  2, OK,   64'hFFFF_FFFF_8000_0000,  32'h0018, 8'h00, 64'h0};
    vecs[14] = '{1, 1, 3, 0, 32'h0028, 64'h1122_3344_5566_7788, 64'h0,                    0, OK,   64'h0,                    32'h0028, 8'hFF, 64'h1122_3344_5566_7788};
    vecs[15] = '{1, 1, 2, 0, 32'h0024, 64'hDEAD_BEEF,           64'h0,                    1, OK,   64'h0,                    32'h0020, 8'hF0, 64'hDEAD_BEEF_0000_0000};
    vecs[16] = '{1, 0, 2, 0, 32'h0022, 64'h0,                   64'h0,                    0, ADEL, 64'h0,                    32'h0,    8'h00, 64'h0};
    vecs[17] = '{1, 1, 3, 0, 32'h002C, 64'h1,                   64'h0,                    0, ADES, 64'h0,                    32'h0,    8'h00, 64'h0};
    vecs[18] = '{1, 0, 0, 1, 32'h0017, 64'h0,                   64'h7F00_0000_0000_0000,  3, OK,   64'h7F,                   32'h0010, 8'h00, 64'h0};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst32_ctrl", 64'({req32, we32, be32, ov32, adel32, ades32, to32, stall32, st32}), 64'd0);
    chk("rst32_data", 64'(|{baddr32, bwd32, rd32}), 64'd0);
    chk("rst64_ctrl", 64'({req64, we64, be64, ov64, adel64, ades64, to64, stall64, st64}), 64'd0);
    chk("rst64_data", 64'(|{baddr64, bwd64, rd64}), 64'd0);

    for (int i = 0; i < 19; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Load a nonzero out_rdata, then reset in the second wait cycle of a lw.
    run_vec('{0, 0, 2, 0, 32'h0070, 64'h0, 64'h1357_9BDF, 0, OK, 64'h1357_9BDF, 32'h0070, 8'h00, 64'h0}, "pre_rst");
    @(posedge clk); #1;
    sel = 1'b0; v32 = 1'b1; wr = 1'b0; sz = 2'd2; sg = 1'b0; addr = 32'h50; rdata = 64'h2468_ACE0;
    @(posedge clk); #1;
    chk("rw_req_wait1", 64'(req32), 64'd1);
    @(posedge clk); #1;
    chk("rw_req_wait2", 64'(req32), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0;
    #1;
    chk("rw_rst_ctrl", 64'({req32, we32, be32, ov32, adel32, ades32, to32, stall32, st32}), 64'd0);
    chk("rw_rst_addr", 64'(baddr32), 64'd0);
    chk("rw_rst_rdata", 64'(rd32), 64'd0);
    reset = 1'b0; ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    chk("rw_late_ack", 64'({req32, ov32, adel32, ades32, to32, st32}), 64'd0);
    chk("rw_late_rdata", 64'(rd32), 64'd0);
    run_vec('{0, 0, 2, 0, 32'h0060, 64'h0, 64'hCAFE_F00D, 1, OK, 64'hCAFE_F00D, 32'h0060, 8'h00, 64'h0}, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
